ltile_clb_ff_bank_scan: RTL and testbench
=========================================

Name: ltile_clb_ff_bank_scan

Overview:
- Parametrised bank of NUM_FF logic-tile flip-flops sharing one clock.
- Each flip-flop has functional capture with a per-bit clock enable, plus a serial scan chain.
- A small scan controller FSM runs counted shift bursts and test-mode capture with a start/busy/done handshake.
- Sits in the CLB in place of single scan-FF instances, one bank per fabric FF group, and feeds the tile-level scan chain.

Parameters:
- NUM_FF, 8, number of flip-flops in the bank and scan-chain length; legal range 2..64.
- RESET_VAL, {NUM_FF{1'b0}}, value loaded into ff_Q on reset.
- CNT_W, $clog2(NUM_FF+1), width of the shift counter; derived, not overridden.

Ports:
- clk  input  1  tile clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Test_en  input  1  0 = functional mode, 1 = test mode.
- ff_D  input  NUM_FF  functional data inputs.
- ff_ce  input  NUM_FF  per-bit functional clock enable.
- ff_Q  output  NUM_FF  flip-flop outputs.
- scan_in  input  1  serial scan data into bit 0.
- scan_out  output  1  serial scan data; combinational copy of ff_Q[NUM_FF-1].
- scan_start  input  1  request a shift burst of NUM_FF bits.
- scan_capture  input  1  test-mode parallel load of ff_D.
- scan_busy  output  1  high while in SHIFT.
- scan_done  output  1  one-cycle pulse after the last shift.
- scan_parity  output  1  XOR of the bits shifted in; present only under the macro below.

Behaviour:
- Reset (reset=1 at a clk edge):
  - ff_Q = RESET_VAL, state = IDLE, counter = 0.
  - scan_busy = 0, scan_done = 0, parity accumulator = 0.
  - Reset overrides every other input, including in mid-burst.
- Functional mode (Test_en=0):
  - Per bit: ff_Q[i] <= ff_D[i] when ff_ce[i]=1, otherwise ff_Q[i] holds.
  - FSM forced to IDLE; scan_start and scan_capture are ignored.
- Test mode, state IDLE:
  - ff_Q holds by default; ff_ce is ignored.
  - scan_capture=1: ff_Q <= ff_D on all bits.
  - scan_start=1 (with scan_capture=0): accepted; counter <= NUM_FF, state -> SHIFT. No shift happens on the accepting edge.
  - scan_start and scan_capture together: capture wins and start is dropped. The requester must reassert start.
- Test mode, state SHIFT:
  - Each edge shifts the chain: ff_Q <= {ff_Q[NUM_FF-2:0], scan_in} and the counter decrements.
  - scan_busy=1 throughout; scan_start and scan_capture are ignored.
  - On the edge where the counter goes 1->0: state -> IDLE and scan_done is registered high for exactly the next cycle.
  - Latency: start accepted at edge k; shifts on edges k+1..k+NUM_FF; scan_done high in the cycle after edge k+NUM_FF.
- Abort: Test_en falling during SHIFT returns the FSM to IDLE on that edge.
  - No scan_done pulse; counter cleared.
  - The functional update (ff_ce/ff_D) applies on that same edge.
- scan_out is valid in every mode. The first bit out of a burst is the pre-burst ff_Q[NUM_FF-1].
- Back-to-back bursts: scan_start sampled in the scan_done cycle (state already IDLE) is accepted, giving a one-cycle gap between bursts.

Optional Feature:
- Macro: LTILE_FF_SCAN_PARITY_EN.
- With the macro defined:
  - A parity accumulator clears when a start is accepted and XORs in scan_in on every shift edge.
  - scan_parity outputs the accumulator; it is stable from the scan_done cycle until the next accepted start.
  - An abort clears the accumulator.
- Without the macro: no accumulator flop, and the scan_parity port is absent.

Decomposition:
- Package ltile_ff_scan_pkg:
  - FSM state enum: IDLE, SHIFT.
  - clog2-based counter-width helper.
  - Shared constant for the maximum NUM_FF (64).
- Sub-module ltile_ff_scan_fsm:
  - Contains the state register, shift counter, busy/done generation and parity accumulator.
  - Outputs shift_en and cap_en strobes to the flop datapath in the parent.

Test Plan:
- Reset: NUM_FF=8, RESET_VAL=8'hA5, reset=1 for 2 cycles with random inputs -> ff_Q=8'hA5, scan_busy=0, scan_done=0.
- Functional enable: Test_en=0, ff_D=8'hFF, ff_ce=8'h0F, starting from ff_Q=8'h00 -> after one edge ff_Q=8'h0F; scan_start pulse ignored, scan_busy stays 0.
- Full shift: Test_en=1, ff_Q=8'h81, scan_start pulse, then scan_in serial 1,0,1,1,0,0,1,0:
  - scan_busy=1 for 8 cycles; scan_out sequence = 1,0,0,0,0,0,0,1.
  - Final ff_Q=8'hB2 (first bit in ends at bit 7); scan_done pulse width 1.
  - With LTILE_FF_SCAN_PARITY_EN: scan_parity=0.
- Capture priority: Test_en=1, IDLE, ff_D=8'h3C, scan_start and scan_capture together -> ff_Q=8'h3C, no burst, scan_busy=0.
- Abort: drop Test_en after 3 shifts of a burst, with ff_ce=0 -> FSM in IDLE next cycle, no scan_done, ff_Q keeps the 3-shift value.
- Reset mid-burst: assert reset after 5 shifts -> ff_Q=RESET_VAL, scan_busy=0, no scan_done; a new scan_start afterwards runs a full 8-shift burst.

Source files
------------

// File: rtl/ltile_ff_scan_pkg.sv
// Shared types and helpers for the logic-tile scan FF bank.
// Holds the scan FSM state enum, counter-width helper and bank size limit.
package ltile_ff_scan_pkg;

  localparam int MAX_NUM_FF = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } scan_state_e;

  // Width needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ltile_clb_ff_bank_scan_fsm.sv
// Scan controller: state, shift counter, busy/done and parity accumulator.
// Ports: clk, reset, test_en, scan_start, scan_capture, scan_in in;
// shift_en, cap_en strobes, scan_busy, scan_done
// (+ scan_parity with LTILE_FF_SCAN_PARITY_EN) out.
module ltile_ff_scan_fsm
  import ltile_ff_scan_pkg::*;
#(
  parameter int NUM_FF = 8,
  parameter int CNT_W  = cnt_width(NUM_FF)
) (
  input  logic clk,
  input  logic reset,
  input  logic test_en,
  input  logic scan_start,
  input  logic scan_capture,
  input  logic scan_in,
  output logic shift_en,
  output logic cap_en,
  output logic scan_busy,
`ifdef LTILE_FF_SCAN_PARITY_EN
  output logic scan_parity,
`endif
  output logic scan_done
);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
`ifdef LTILE_FF_SCAN_PARITY_EN
  logic             par_q, par_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shift_en = 1'b0;
    cap_en   = 1'b0;
`ifdef LTILE_FF_SCAN_PARITY_EN
    par_d    = par_q;
`endif
    if (!test_en) begin
      // Functional mode; leaving SHIFT here is an abort.
      state_d = IDLE;
      cnt_d   = '0;
`ifdef LTILE_FF_SCAN_PARITY_EN
      if (state_q == SHIFT) par_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (scan_capture) begin
            // Capture wins; a simultaneous start is dropped.
            cap_en = 1'b1;
          end else if (scan_start) begin
            state_d = SHIFT;
            cnt_d   = CNT_W'(NUM_FF);
`ifdef LTILE_FF_SCAN_PARITY_EN
            par_d   = 1'b0;
`endif
          end
        end
        SHIFT: begin
          shift_en = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
`ifdef LTILE_FF_SCAN_PARITY_EN
          par_d    = par_q ^ scan_in;
`endif
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef LTILE_FF_SCAN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef LTILE_FF_SCAN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign scan_busy = (state_q == SHIFT);
  assign scan_done = done_q;
`ifdef LTILE_FF_SCAN_PARITY_EN
  assign scan_parity = par_q;
`else
  // scan_in only feeds the parity accumulator inside this block.
  logic unused_scan_in;
  assign unused_scan_in = scan_in;
`endif

endmodule

// File: rtl/ltile_clb_ff_bank_scan.sv
// Bank of NUM_FF tile flip-flops with per-bit enable and a counted scan chain.
// Ports: clk, reset, Test_en, ff_D, ff_ce, scan_in, scan_start, scan_capture
// in; ff_Q, scan_out, scan_busy, scan_done out; scan_parity out only when
// LTILE_FF_SCAN_PARITY_EN is defined.
module ltile_clb_ff_bank_scan
  import ltile_ff_scan_pkg::*;
#(
  parameter int                NUM_FF    = 8,
  parameter logic [NUM_FF-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = cnt_width(NUM_FF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Test_en,
  input  logic [NUM_FF-1:0] ff_D,
  input  logic [NUM_FF-1:0] ff_ce,
  output logic [NUM_FF-1:0] ff_Q,
  input  logic              scan_in,
  output logic              scan_out,
  input  logic              scan_start,
  input  logic              scan_capture,
  output logic              scan_busy,
`ifdef LTILE_FF_SCAN_PARITY_EN
  output logic              scan_parity,
`endif
  output logic              scan_done
);

  logic [NUM_FF-1:0] ff_q, ff_d;
  logic              shift_en;
  logic              cap_en;

  ltile_ff_scan_fsm #(
    .NUM_FF (NUM_FF),
    .CNT_W  (CNT_W)
  ) u_fsm (
    .clk          (clk),
    .reset        (reset),
    .test_en      (Test_en),
    .scan_start   (scan_start),
    .scan_capture (scan_capture),
    .scan_in      (scan_in),
    .shift_en     (shift_en),
    .cap_en       (cap_en),
    .scan_busy    (scan_busy),
`ifdef LTILE_FF_SCAN_PARITY_EN
    .scan_parity  (scan_parity),
`endif
    .scan_done    (scan_done)
  );

  always_comb begin
    ff_d = ff_q;
    if (!Test_en) begin
      ff_d = (ff_D & ff_ce) | (ff_q & ~ff_ce);
    end else if (cap_en) begin
      ff_d = ff_D;
    end else if (shift_en) begin
      // First bit in travels up to the top bit by the end of the burst.
      ff_d = {ff_q[NUM_FF-2:0], scan_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ff_q <= RESET_VAL;
    end else begin
      ff_q <= ff_d;
    end
  end

  assign ff_Q     = ff_q;
  assign scan_out = ff_q[NUM_FF-1];

endmodule

// File: tb/tb_ltile_clb_ff_bank_scan.sv
// Self-checking bench for ltile_clb_ff_bank_scan (NUM_FF=8, RESET_VAL=A5).
// Directed plan steps followed by random stimulus against a reference model.
module tb_ltile_clb_ff_bank_scan;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset, Test_en, scan_in, scan_start, scan_capture;
  logic [7:0] ff_D, ff_ce, ff_Q;
  logic       scan_out, scan_busy, scan_done;
`ifdef LTILE_FF_SCAN_PARITY_EN
  logic       scan_parity;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: register image, shifts left in the burst, done, parity.
  logic [7:0] m_q;
  int         m_left;
  logic       m_done;
  logic       m_par;

  always #5 clk = ~clk;

  ltile_clb_ff_bank_scan #(
    .NUM_FF    (8),
    .RESET_VAL (RV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Test_en      (Test_en),
    .ff_D         (ff_D),
    .ff_ce        (ff_ce),
    .ff_Q         (ff_Q),
    .scan_in      (scan_in),
    .scan_out     (scan_out),
    .scan_start   (scan_start),
    .scan_capture (scan_capture),
    .scan_busy    (scan_busy),
`ifdef LTILE_FF_SCAN_PARITY_EN
    .scan_parity  (scan_parity),
`endif
    .scan_done    (scan_done)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge from the inputs now applied.
  task automatic model_edge();
    if (reset) begin
      m_q = RV; m_left = 0; m_done = 1'b0; m_par = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!Test_en) begin
        m_q = (ff_D & ff_ce) | (m_q & ~ff_ce);
        if (m_left > 0) m_par = 1'b0;
        m_left = 0;
      end else if (m_left > 0) begin
        m_q = {m_q[6:0], scan_in};
        m_par = m_par ^ scan_in;
        m_left = m_left - 1;
        if (m_left == 0) m_done = 1'b1;
      end else if (scan_capture) begin
        m_q = ff_D;
      end else if (scan_start) begin
        m_left = 8;
        m_par = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("ff_Q", ff_Q, m_q);
    chk("scan_out", {7'b0, scan_out}, {7'b0, m_q[7]});
    chk("busy", {7'b0, scan_busy}, {7'b0, m_left > 0});
    chk("done", {7'b0, scan_done}, {7'b0, m_done});
`ifdef LTILE_FF_SCAN_PARITY_EN
    if (m_left == 0) chk("parity", {7'b0, scan_parity}, {7'b0, m_par});
`endif
  endtask

  task automatic idle_in(input logic te);
    reset = 0; Test_en = te; scan_in = 0;
    scan_start = 0; scan_capture = 0; ff_ce = 8'h00;
  endtask

  initial begin
    logic [7:0] bits;
    logic [7:0] outs;
    logic [7:0] snap;
    int busy_n, done_n;
    m_q = 8'h00; m_left = 0; m_done = 0; m_par = 0;

    // Reset for two cycles with random other inputs.
    for (int i = 0; i < 2; i++) begin
      reset = 1; Test_en = 1'($urandom); scan_in = 1'($urandom);
      scan_start = 1'($urandom); scan_capture = 1'($urandom);
      ff_D = 8'($urandom); ff_ce = 8'($urandom);
      tick();
    end
    chk("reset_val", ff_Q, 8'hA5);

    // Functional enable from 00.
    idle_in(0); ff_D = 8'h00; ff_ce = 8'hFF; tick();
    ff_D = 8'hFF; ff_ce = 8'h0F; tick();
    chk("func_ce", ff_Q, 8'h0F);
    ff_ce = 8'h00; scan_start = 1; tick();
    scan_start = 0; tick();
    chk("func_start_ignored", {7'b0, scan_busy}, 8'h00);

    // Full shift of 81 with serial 1,0,1,1,0,0,1,0.
    ff_D = 8'h81; ff_ce = 8'hFF; tick();
    idle_in(1); scan_start = 1; tick();
    scan_start = 0;
    bits = 8'b10110010;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 8; i++) begin
      outs[7-i] = scan_out;
      busy_n += int'(scan_busy);
      scan_in = bits[7-i];
      tick();
      done_n += int'(scan_done);
    end
    chk("shift_out_seq", outs, 8'b10000001);
    chk("shift_final", ff_Q, 8'hB2);
    chk("shift_busy_cycles", 8'(busy_n), 8'd8);
    chk("shift_done_now", {7'b0, scan_done}, 8'h01);
`ifdef LTILE_FF_SCAN_PARITY_EN
    chk("shift_parity", {7'b0, scan_parity}, 8'h00);
`endif
    scan_in = 0; tick();
    done_n += int'(scan_done);
    chk("done_width", 8'(done_n), 8'd1);

    // Capture beats start.
    ff_D = 8'h3C; scan_start = 1; scan_capture = 1; tick();
    chk("cap_val", ff_Q, 8'h3C);
    scan_start = 0; scan_capture = 0; tick();
    chk("cap_no_burst", {7'b0, scan_busy}, 8'h00);

    // Abort after three shifts.
    scan_start = 1; tick();
    scan_start = 0; scan_in = 1;
    for (int i = 0; i < 3; i++) tick();
    snap = ff_Q;
    chk("abort_pre", snap, 8'hE7);
    Test_en = 0; ff_ce = 8'h00; ff_D = 8'h00; tick();
    chk("abort_hold", ff_Q, snap);
    chk("abort_busy", {7'b0, scan_busy}, 8'h00);
    Test_en = 1; tick();
    chk("abort_no_done", {7'b0, scan_done}, 8'h00);

    // Reset after five shifts, then a full burst.
    scan_start = 1; tick();
    scan_start = 0;
    for (int i = 0; i < 5; i++) begin scan_in = 1'($urandom); tick(); end
    reset = 1; tick();
    chk("midrst_q", ff_Q, 8'hA5);
    reset = 0; tick();
    chk("midrst_done", {7'b0, scan_done}, 8'h00);
    scan_start = 1; tick();
    scan_start = 0; busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      busy_n += int'(scan_busy);
      scan_in = 1'b0;
      tick();
    end
    chk("midrst_burst_len", 8'(busy_n), 8'd8);
    chk("midrst_burst_q", ff_Q, 8'h00);

    // Random phase, including back-to-back starts and aborts.
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(63) == 0);
      Test_en      = ($urandom_range(31) != 0);
      scan_start   = ($urandom_range(3) == 0);
      scan_capture = ($urandom_range(15) == 0);
      scan_in      = 1'($urandom);
      ff_D         = 8'($urandom);
      ff_ce        = 8'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
